// File: rtl/refchk_pkg.sv
// Shared types and default sizing for the ILA/RTL refinement checker.
package refchk_pkg;

    localparam int unsigned NUM_MAPS_DFLT   = 30;
    localparam int unsigned MAX_CYCLES_DFLT = 132;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/refchk_prio_enc.sv
// Lowest-set-bit priority encoder; an all-zero vector encodes as index 0.
module refchk_prio_enc #(
    parameter int unsigned W     = 30,
    parameter int unsigned IDX_W = 5
) (
    input  logic [W-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_c
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx_c = '0;
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/refinement_checker.sv
// End-of-instruction refinement checker: times the instruction window and
// latches a single sticky pass / mismatch / timeout verdict until cleared.
module refinement_checker
    import refchk_pkg::*;
#(
    parameter int unsigned NUM_MAPS   = NUM_MAPS_DFLT,
    parameter int unsigned MAX_CYCLES = MAX_CYCLES_DFLT,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned IDX_W      = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                start_i,
    input  logic                commit_i,
    input  logic [NUM_MAPS-1:0] match_i,
    input  logic [NUM_MAPS-1:0] map_en_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic                fail_o,
    output logic                timeout_o,
    output logic [CNT_W-1:0]    cycle_cnt_o,
    output logic [NUM_MAPS-1:0] mismatch_o,
    output logic [IDX_W-1:0]    first_fail_idx_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_CNT  = CNT_W'(MAX_CYCLES);

    state_e              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                fail_q, fail_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_MAPS-1:0] mismatch_q, mismatch_d;
    logic [NUM_MAPS-1:0] commit_mm;

    assign commit_mm = ~match_i & map_en_i;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;
        mismatch_d = mismatch_q;

        if (clear_i) begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            pass_d     = 1'b0;
            fail_d     = 1'b0;
            timeout_d  = 1'b0;
            cnt_d      = '0;
            mismatch_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d    = RUN;
                        busy_d     = 1'b1;
                        done_d     = 1'b0;
                        pass_d     = 1'b0;
                        fail_d     = 1'b0;
                        timeout_d  = 1'b0;
                        cnt_d      = '0;
                        mismatch_d = '0;
                    end
                end
                RUN: begin
                    // Commit wins over a timeout in the same cycle.
                    if (commit_i) begin
                        state_d    = DONE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        mismatch_d = commit_mm;
                        pass_d     = (commit_mm == '0);
                        fail_d     = (commit_mm != '0);
                        timeout_d  = 1'b0;
                    end else if (cnt_q == LAST_CNT) begin
                        state_d    = DONE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        mismatch_d = '0;
                        pass_d     = 1'b0;
                        fail_d     = 1'b1;
                        timeout_d  = 1'b1;
                        cnt_d      = TMO_CNT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
            mismatch_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
            mismatch_q <= mismatch_d;
        end
    end

    refchk_prio_enc #(
        .W     (NUM_MAPS),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .vec_i (mismatch_q),
        .idx_c (first_fail_idx_o)
    );

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign timeout_o   = timeout_q;
    assign cycle_cnt_o = cnt_q;
    assign mismatch_o  = mismatch_q;

    // Verdict consistency invariants.
    a_pass_fail_excl: assert property (@(posedge clk) disable iff (rst) !(pass_q && fail_q));
    a_verdict_done:   assert property (@(posedge clk) disable iff (rst) (pass_q || fail_q) |-> done_q);
    a_timeout_fail:   assert property (@(posedge clk) disable iff (rst) timeout_q |-> fail_q);

endmodule

// File: tb/tb_refinement_checker.sv
// Self-checking bench for refinement_checker: directed vector table, hand-built
// corner sequences and randomized transactions against a transaction-level model.
module tb_refinement_checker;

    localparam int unsigned NM = 30;
    localparam int unsigned MC = 132;
    localparam int unsigned CW = 8;
    localparam int unsigned IW = 5;
    localparam int NVEC = 9;

    typedef struct {
        logic          done;
        logic          pass;
        logic          fail;
        logic          tmo;
        logic          busy;
        logic [CW-1:0] cnt;
        logic [NM-1:0] mm;
        logic [IW-1:0] idx;
    } exp_t;

    typedef struct {
        int            delay;
        logic [NM-1:0] match;
        logic [NM-1:0] en;
        exp_t          exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear_i = 1'b0;
    logic          start_i = 1'b0;
    logic          commit_i = 1'b0;
    logic [NM-1:0] match_i = '0;
    logic [NM-1:0] map_en_i = '0;
    logic          busy_o, done_o, pass_o, fail_o, timeout_o;
    logic [CW-1:0] cycle_cnt_o;
    logic [NM-1:0] mismatch_o;
    logic [IW-1:0] first_fail_idx_o;

    int checks = 0;
    int errors = 0;
    vec_t vecs [NVEC];

    refinement_checker #(
        .NUM_MAPS   (NM),
        .MAX_CYCLES (MC),
        .CNT_W      (CW),
        .IDX_W      (IW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .clear_i          (clear_i),
        .start_i          (start_i),
        .commit_i         (commit_i),
        .match_i          (match_i),
        .map_en_i         (map_en_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .pass_o           (pass_o),
        .fail_o           (fail_o),
        .timeout_o        (timeout_o),
        .cycle_cnt_o      (cycle_cnt_o),
        .mismatch_o       (mismatch_o),
        .first_fail_idx_o (first_fail_idx_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input logic d, input logic p, input logic f, input logic t,
                                input logic b, input int c, input logic [NM-1:0] m, input int i);
        exp_t r;
        r.done = d; r.pass = p; r.fail = f; r.tmo = t; r.busy = b;
        r.cnt = CW'(c); r.mm = m; r.idx = IW'(i);
        return r;
    endfunction

    // Transaction-level expectation: delay = RUN cycles before commit, <0 = never.
    function automatic exp_t model(input int delay, input logic [NM-1:0] m, input logic [NM-1:0] e);
        exp_t r;
        bit found;
        r = mk(1, 0, 0, 0, 0, 0, '0, 0);
        if (delay < 0 || delay >= int'(MC)) begin
            r.fail = 1'b1; r.tmo = 1'b1; r.cnt = CW'(MC);
        end else begin
            r.cnt = CW'(delay);
            found = 1'b0;
            for (int i = 0; i < int'(NM); i++) begin
                if (e[i] && !m[i]) begin
                    r.mm[i] = 1'b1;
                    if (!found) begin r.idx = IW'(i); found = 1'b1; end
                end
            end
            r.pass = !found;
            r.fail = found;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", tag, act, req);
        end
    endtask

    task automatic check_all(input string name, input exp_t e);
        check({name, ".done"},    32'(done_o),           32'(e.done));
        check({name, ".pass"},    32'(pass_o),           32'(e.pass));
        check({name, ".fail"},    32'(fail_o),           32'(e.fail));
        check({name, ".timeout"}, 32'(timeout_o),        32'(e.tmo));
        check({name, ".busy"},    32'(busy_o),           32'(e.busy));
        check({name, ".cnt"},     32'(cycle_cnt_o),      32'(e.cnt));
        check({name, ".mm"},      32'(mismatch_o),       32'(e.mm));
        check({name, ".idx"},     32'(first_fail_idx_o), 32'(e.idx));
    endtask

    task automatic scramble();
        match_i  = NM'($urandom);
        map_en_i = NM'($urandom);
    endtask

    task automatic clear_and_start();
        @(negedge clk); clear_i = 1'b1;
        @(negedge clk); clear_i = 1'b0; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
    endtask

    // Leaves the bench at the first negedge after the verdict edge.
    task automatic run_txn(input int delay, input logic [NM-1:0] m, input logic [NM-1:0] e);
        clear_and_start();
        if (delay < 0 || delay >= int'(MC)) begin
            for (int k = 0; k < int'(MC); k++) begin
                scramble();
                @(negedge clk);
            end
        end else begin
            for (int k = 0; k < delay; k++) begin
                scramble();
                @(negedge clk);
            end
            commit_i = 1'b1; match_i = m; map_en_i = e;
            @(negedge clk);
            commit_i = 1'b0;
            scramble();
        end
    endtask

    task automatic add_vec(input int n, input int d, input logic [NM-1:0] m,
                           input logic [NM-1:0] e, input exp_t x);
        vecs[n].delay = d; vecs[n].match = m; vecs[n].en = e; vecs[n].exp = x;
    endtask

    initial begin
        exp_t zero;
        exp_t ex;
        logic [NM-1:0] m, e;
        int d;

        zero = mk(0, 0, 0, 0, 0, 0, '0, 0);

        add_vec(0, 5,   '1,            '1,        mk(1, 1, 0, 0, 0, 5,   '0,            0));
        add_vec(1, 5,   ~NM'('h408),   '1,        mk(1, 0, 1, 0, 0, 5,   NM'('h408),    3));
        add_vec(2, 5,   ~NM'('h8),     ~NM'('h8), mk(1, 1, 0, 0, 0, 5,   '0,            0));
        add_vec(3, -1,  '1,            '1,        mk(1, 0, 1, 1, 0, 132, '0,            0));
        add_vec(4, 131, '1,            '1,        mk(1, 1, 0, 0, 0, 131, '0,            0));
        add_vec(5, 131, ~NM'(1 << 29), '1,        mk(1, 0, 1, 0, 0, 131, NM'(1 << 29),  29));
        add_vec(6, 0,   '1,            '1,        mk(1, 1, 0, 0, 0, 0,   '0,            0));
        add_vec(7, 17,  '0,            '1,        mk(1, 0, 1, 0, 0, 17,  '1,            0));
        add_vec(8, 9,   '0,            '0,        mk(1, 1, 0, 0, 0, 9,   '0,            0));

        // Reset state
        #2;
        check_all("reset", zero);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check_all("post_reset", zero);

        for (int n = 0; n < NVEC; n++) begin
            run_txn(vecs[n].delay, vecs[n].match, vecs[n].en);
            check_all($sformatf("vec%0d", n), vecs[n].exp);
        end

        // Timeout boundary: still running on the last RUN cycle, verdict one edge later.
        clear_and_start();
        for (int k = 0; k < int'(MC) - 1; k++) @(negedge clk);
        check_all("tmo_last_run", mk(0, 0, 0, 0, 1, 131, '0, 0));
        @(negedge clk);
        check_all("tmo_edge", mk(1, 0, 1, 1, 0, 132, '0, 0));

        // Single-shot: start and failing commit in DONE are ignored.
        run_txn(5, '1, '1);
        start_i = 1'b1; commit_i = 1'b1; match_i = '0; map_en_i = '1;
        @(negedge clk); start_i = 1'b0; commit_i = 1'b0;
        @(negedge clk);
        check_all("single_shot", mk(1, 1, 0, 0, 0, 5, '0, 0));

        // clear beats start in the same cycle; block stays idle afterwards.
        clear_i = 1'b1; start_i = 1'b1;
        @(negedge clk); clear_i = 1'b0; start_i = 1'b0;
        check_all("clear_start", zero);
        @(negedge clk);
        check_all("clear_start_idle", zero);
        commit_i = 1'b1; match_i = '0; map_en_i = '1;
        @(negedge clk); commit_i = 1'b0;
        check_all("idle_commit", zero);

        // clear mid-RUN aborts silently.
        clear_and_start();
        for (int k = 0; k < 3; k++) @(negedge clk);
        check_all("mid_run", mk(0, 0, 0, 0, 1, 3, '0, 0));
        clear_i = 1'b1; commit_i = 1'b1;
        @(negedge clk); clear_i = 1'b0; commit_i = 1'b0;
        check_all("clear_mid_run", zero);

        // Asynchronous reset mid-window, then a normal pass.
        clear_and_start();
        for (int k = 0; k < 3; k++) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all("async_rst", zero);
        @(negedge clk); rst = 1'b0;
        run_txn(4, '1, '1);
        check_all("after_rst", mk(1, 1, 0, 0, 0, 4, '0, 0));

        // Randomized transactions against the model.
        for (int n = 0; n < 40; n++) begin
            d = int'($urandom_range(0, 150));
            if (d > 140) d = -1;
            case ($urandom_range(0, 2))
                0:       m = '1;
                1:       m = ~(NM'(1) << $urandom_range(0, NM - 1));
                default: m = NM'($urandom);
            endcase
            e = ($urandom_range(0, 1) == 0) ? '1 : NM'($urandom);
            ex = model(d, m, e);
            run_txn(d, m, e);
            check_all($sformatf("rand%0d", n), ex);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
